// File: rtl/pixel_stream_proc_if.sv
// rtl/pixel_stream_proc_if.sv - valid/ready RGB pixel stream bundle
interface pixel_stream_proc_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] red;
    logic [DATA_W-1:0] green;
    logic [DATA_W-1:0] blue;

    modport master (output valid, output red, output green, output blue, input ready);
    modport slave  (input valid, input red, input green, input blue, output ready);
endinterface

// File: rtl/pixel_stream_proc.sv
// rtl/pixel_stream_proc.sv - frame-based RGB pixel processor, two-stage pipeline
module pixel_stream_proc #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 12
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [1:0]          OPCODE,
    input  logic [DATA_W:0]     OFFSET,
    input  logic [DATA_W-1:0]   THRESH,
    input  logic [DIM_W-1:0]    READ_WIDTH,
    input  logic [DIM_W-1:0]    READ_HEIGHT,
    pixel_stream_proc_if.slave  in_pix,
    pixel_stream_proc_if.master out_pix,
    output logic [DIM_W-1:0]    WRITE_WIDTH,
    output logic [DIM_W-1:0]    WRITE_HEIGHT,
    output logic [DIM_W-1:0]    WRITE_ROW,
    output logic [DIM_W-1:0]    WRITE_COL,
    output logic                BUSY,
    output logic                DONE
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [1:0] OP_BRIGHT = 2'd0;
    localparam logic [1:0] OP_GRAY   = 2'd1;
    localparam logic [1:0] OP_ROT90  = 2'd2;
    localparam logic [1:0] OP_THRESH = 2'd3;
    localparam int         YW        = 16 + DATA_W;

    state_t state_q, state_d;

    logic [1:0]        op_q;
    logic [DATA_W:0]   offset_q;
    logic [DATA_W-1:0] thresh_q;
    logic [DIM_W-1:0]  w_q, h_q;
    logic [DIM_W-1:0]  src_row_q, src_col_q;

    logic              s1_valid_q, s1_last_q;
    logic [DATA_W-1:0] s1_red_q, s1_green_q, s1_blue_q;
    logic [DIM_W-1:0]  s1_row_q, s1_col_q;

    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_red_q, out_green_q, out_blue_q;
    logic [DIM_W-1:0]  out_row_q, out_col_q;

    logic              zero_done_q;

    logic adv, in_hs, out_hs, src_last, start_ok, start_empty;
    logic [DATA_W-1:0] res_red, res_green, res_blue, gray_y;
    logic [DIM_W-1:0]  res_row, res_col;
    logic [YW-1:0]     y_full;

    // Saturating signed add of the brightness offset, evaluated at DATA_W+2 bits
    function automatic logic [DATA_W-1:0] clamp_add(input logic [DATA_W-1:0] ch, input logic [DATA_W:0] off);
        logic signed [DATA_W+1:0] s;
        s = $signed({2'b00, ch}) + $signed({off[DATA_W], off});
        if (s < 0)
            return '0;
        else if (s > $signed({2'b00, {DATA_W{1'b1}}}))
            return '1;
        else
            return s[DATA_W-1:0];
    endfunction

    assign adv         = !out_valid_q || out_pix.ready;
    assign in_pix.ready = (state_q == ST_RUN) && adv;
    assign in_hs       = in_pix.valid && in_pix.ready;
    assign out_hs      = out_valid_q && out_pix.ready;
    assign src_last    = (src_row_q == h_q - DIM_W'(1)) && (src_col_q == w_q - DIM_W'(1));
    assign start_ok    = (state_q == ST_IDLE) && START;
    assign start_empty = (READ_WIDTH == '0) || (READ_HEIGHT == '0);

    assign out_pix.valid = out_valid_q;
    assign out_pix.red   = out_red_q;
    assign out_pix.green = out_green_q;
    assign out_pix.blue  = out_blue_q;
    assign WRITE_ROW     = out_row_q;
    assign WRITE_COL     = out_col_q;
    assign WRITE_WIDTH   = (op_q == OP_ROT90) ? h_q : w_q;
    assign WRITE_HEIGHT  = (op_q == OP_ROT90) ? w_q : h_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = zero_done_q || ((state_q == ST_DRAIN) && out_hs && out_last_q);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: empty frames never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START && !start_empty) state_d = ST_RUN;
            ST_RUN:   if (in_hs && src_last)     state_d = ST_DRAIN;
            ST_DRAIN: if (out_hs && out_last_q)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Frame configuration captured on an accepted START
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_q <= '0; offset_q <= '0; thresh_q <= '0; w_q <= '0; h_q <= '0; zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_ok && start_empty;
            if (start_ok) begin
                op_q     <= OPCODE;
                offset_q <= OFFSET;
                thresh_q <= THRESH;
                w_q      <= READ_WIDTH;
                h_q      <= READ_HEIGHT;
            end
        end
    end

    // Raster coordinate of the next source pixel
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            src_row_q <= '0; src_col_q <= '0;
        end else if (start_ok) begin
            src_row_q <= '0; src_col_q <= '0;
        end else if (in_hs) begin
            if (src_col_q == w_q - DIM_W'(1)) begin
                src_col_q <= '0;
                src_row_q <= src_row_q + DIM_W'(1);
            end else begin
                src_col_q <= src_col_q + DIM_W'(1);
            end
        end
    end

    // Stage-2 datapath: per-op pixel result and destination coordinate
    always_comb begin
        y_full    = YW'(in_zero(s1_red_q)) * YW'(77) + YW'(s1_green_q) * YW'(150) + YW'(s1_blue_q) * YW'(29);
        gray_y    = DATA_W'(y_full >> 8);
        res_red   = s1_red_q;
        res_green = s1_green_q;
        res_blue  = s1_blue_q;
        res_row   = s1_row_q;
        res_col   = s1_col_q;
        case (op_q)
            OP_BRIGHT: begin
                res_red   = clamp_add(s1_red_q, offset_q);
                res_green = clamp_add(s1_green_q, offset_q);
                res_blue  = clamp_add(s1_blue_q, offset_q);
            end
            OP_GRAY: begin
                res_red = gray_y; res_green = gray_y; res_blue = gray_y;
            end
            OP_ROT90: begin
                res_row = s1_col_q;
                res_col = h_q - DIM_W'(1) - s1_row_q;
            end
            OP_THRESH: begin
                res_red   = (gray_y >= thresh_q) ? '1 : '0;
                res_green = res_red;
                res_blue  = res_red;
            end
            default: ;
        endcase
    end

    function automatic logic [DATA_W-1:0] in_zero(input logic [DATA_W-1:0] v);
        return v;
    endfunction

    // Two pipeline stages, both frozen while the output is stalled
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q <= 1'b0; s1_last_q <= 1'b0;
            s1_red_q <= '0; s1_green_q <= '0; s1_blue_q <= '0;
            s1_row_q <= '0; s1_col_q <= '0;
            out_valid_q <= 1'b0; out_last_q <= 1'b0;
            out_red_q <= '0; out_green_q <= '0; out_blue_q <= '0;
            out_row_q <= '0; out_col_q <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_hs;
            s1_last_q   <= src_last;
            s1_red_q    <= in_pix.red;
            s1_green_q  <= in_pix.green;
            s1_blue_q   <= in_pix.blue;
            s1_row_q    <= src_row_q;
            s1_col_q    <= src_col_q;
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_last_q;
            out_red_q   <= res_red;
            out_green_q <= res_green;
            out_blue_q  <= res_blue;
            out_row_q   <= res_row;
            out_col_q   <= res_col;
        end
    end
endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb/tb_pixel_stream_proc.sv - directed self-checking bench for pixel_stream_proc
module tb_pixel_stream_proc;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 12;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              START = 1'b0;
    logic [1:0]        OPCODE = '0;
    logic [DATA_W:0]   OFFSET = '0;
    logic [DATA_W-1:0] THRESH = '0;
    logic [DIM_W-1:0]  READ_WIDTH = '0;
    logic [DIM_W-1:0]  READ_HEIGHT = '0;
    logic [DIM_W-1:0]  WRITE_WIDTH, WRITE_HEIGHT, WRITE_ROW, WRITE_COL;
    logic              BUSY, DONE;

    pixel_stream_proc_if #(.DATA_W(DATA_W)) in_pix();
    pixel_stream_proc_if #(.DATA_W(DATA_W)) out_pix();

    pixel_stream_proc #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .OFFSET(OFFSET),
        .THRESH(THRESH), .READ_WIDTH(READ_WIDTH), .READ_HEIGHT(READ_HEIGHT),
        .in_pix(in_pix), .out_pix(out_pix),
        .WRITE_WIDTH(WRITE_WIDTH), .WRITE_HEIGHT(WRITE_HEIGHT),
        .WRITE_ROW(WRITE_ROW), .WRITE_COL(WRITE_COL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int pr[16], pg[16], pb[16], er[16], eg[16], eb[16], erow[16], ecol[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic set_pix(input int i, input int r, input int g, input int b,
                           input int xr, input int xg, input int xb, input int row, input int col);
        pr[i] = r; pg[i] = g; pb[i] = b;
        er[i] = xr; eg[i] = xg; eb[i] = xb; erow[i] = row; ecol[i] = col;
    endtask

    // Called at a negedge; returns at the negedge after the START edge
    task automatic start_frame(input int op, input int off, input int thr, input int w, input int h);
        OPCODE = 2'(op); OFFSET = 9'(off); THRESH = 8'(thr);
        READ_WIDTH = 12'(w); READ_HEIGHT = 12'(h); START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
    endtask

    // Feeds n pixels and checks every visible result against the expected tables
    task automatic stream(input int n, input bit rnd, input bit chk_lat);
        int idx = 0, oidx = 0, cyc = 0, done_cnt = 0, in_cyc0 = 0;
        bit lat_done = 0;
        while (oidx < n && cyc < 400) begin
            out_pix.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pix.valid  = (idx < n);
            if (idx < n) begin
                in_pix.red = 8'(pr[idx]); in_pix.green = 8'(pg[idx]); in_pix.blue = 8'(pb[idx]);
            end
            #1;
            if (DONE) done_cnt++;
            if (out_pix.valid) begin
                check("out_red",   out_pix.red,   er[oidx]);
                check("out_green", out_pix.green, eg[oidx]);
                check("out_blue",  out_pix.blue,  eb[oidx]);
                check("out_row",   WRITE_ROW,     erow[oidx]);
                check("out_col",   WRITE_COL,     ecol[oidx]);
                if (chk_lat && !lat_done) begin
                    check("latency", cyc - in_cyc0, 2);
                    lat_done = 1;
                end
                if (out_pix.ready) begin
                    check("done_at_hs", DONE, (oidx == n - 1));
                    oidx++;
                end
            end
            if (in_pix.valid && in_pix.ready) begin
                if (idx == 0) in_cyc0 = cyc;
                idx++;
            end
            @(posedge CLK); @(negedge CLK);
            cyc++;
        end
        in_pix.valid = 1'b0;
        out_pix.ready = 1'b1;
        #1;
        check("result_count", oidx, n);
        check("done_count", done_cnt, 1);
        check("busy_after", BUSY, 0);
        check("done_after", DONE, 0);
    endtask

    initial begin
        int bad;
        in_pix.valid = 1'b0; in_pix.red = '0; in_pix.green = '0; in_pix.blue = '0;
        out_pix.ready = 1'b1;

        // Reset state
        @(negedge CLK); #1;
        check("rst_out_valid", out_pix.valid, 0);
        check("rst_in_ready", in_pix.ready, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_wwidth", WRITE_WIDTH, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // 1: reset in the middle of a 4x4 frame after five pixels
        start_frame(0, 0, 0, 4, 4);
        for (int i = 0; i < 5; i++) begin
            in_pix.valid = 1'b1; in_pix.red = 8'(i); in_pix.green = 8'(i); in_pix.blue = 8'(i);
            @(posedge CLK); @(negedge CLK);
        end
        in_pix.valid = 1'b0;
        check("mid_busy", BUSY, 1);
        RESET = 1'b0; #1;
        check("abort_out_valid", out_pix.valid, 0);
        check("abort_in_ready", in_pix.ready, 0);
        check("abort_busy", BUSY, 0);
        check("abort_wwidth", WRITE_WIDTH, 0);
        check("abort_wheight", WRITE_HEIGHT, 0);
        check("abort_row", WRITE_ROW, 0);
        check("abort_col", WRITE_COL, 0);
        check("abort_red", out_pix.red, 0);
        @(negedge CLK);
        RESET = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1; if (DONE || BUSY || out_pix.valid) bad++;
            @(negedge CLK);
        end
        check("abort_quiet", bad, 0);

        // 2: brightness, positive and negative offset, with latency check
        start_frame(0, 100, 0, 1, 1);
        check("bright_busy", BUSY, 1);
        set_pix(0, 200, 10, 155, 255, 110, 255, 0, 0);
        stream(1, 0, 1);
        start_frame(0, -100, 0, 1, 1);
        set_pix(0, 200, 10, 155, 100, 0, 55, 0, 0);
        stream(1, 0, 0);

        // 3: grayscale and threshold (y = (77R+150G+29B)>>8)
        start_frame(1, 0, 0, 2, 1);
        set_pix(0, 255, 255, 255, 255, 255, 255, 0, 0);
        set_pix(1, 100, 200, 50, 152, 152, 152, 0, 1);
        stream(2, 0, 0);
        start_frame(3, 0, 128, 2, 1);
        set_pix(0, 100, 200, 50, 255, 255, 255, 0, 0);
        set_pix(1, 10, 20, 30, 0, 0, 0, 0, 1);
        stream(2, 0, 0);

        // 4: rotate-90 on a 3x2 frame
        start_frame(2, 0, 0, 3, 2);
        check("rot_wwidth", WRITE_WIDTH, 2);
        check("rot_wheight", WRITE_HEIGHT, 3);
        for (int i = 0; i < 6; i++)
            set_pix(i, i * 10, i + 1, 255 - i, i * 10, i + 1, 255 - i, i % 3, 1 - i / 3);
        stream(6, 0, 0);

        // 5: 4x4 brightness with random output backpressure
        start_frame(0, 60, 0, 4, 4);
        check("b4_wwidth", WRITE_WIDTH, 4);
        for (int i = 0; i < 16; i++)
            set_pix(i, i * 16, 255 - i * 9, i * 3 + 200,
                    sat(i * 16 + 60), sat(255 - i * 9 + 60), sat(i * 3 + 260), i / 4, i % 4);
        stream(16, 1, 0);

        // 6: empty frame, then START while busy
        start_frame(0, 0, 0, 0, 4);
        check("empty_done", DONE, 1);
        check("empty_busy", BUSY, 0);
        @(negedge CLK);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1; if (DONE || out_pix.valid) bad++;
            @(negedge CLK);
        end
        check("empty_quiet", bad, 0);

        start_frame(0, 0, 0, 2, 1);
        start_frame(2, 0, 0, 5, 7);
        check("ign_wwidth", WRITE_WIDTH, 2);
        check("ign_wheight", WRITE_HEIGHT, 1);
        check("ign_busy", BUSY, 1);
        set_pix(0, 1, 2, 3, 1, 2, 3, 0, 0);
        set_pix(1, 4, 5, 6, 4, 5, 6, 0, 1);
        stream(2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
